// File: rtl/demux_2_stream.sv
// 1:2 stream demux. Each output has a one-entry register. Optional per-channel transfer counters are built when DEMUX_2_STREAM_CNT_EN is defined.
// Latency: a word accepted at edge k is valid on its channel after edge k (1 cycle). There is no combinational din->dout path.
// Backpressure: in_ready follows only the selected channel (empty, or draining this cycle), so a stalled channel never blocks the other one.
module demux_2_stream #(
    parameter int data_width = 16,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] din,
    input  logic                  sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] dout_0,
    output logic                  valid_0,
    input  logic                  ready_0,
    output logic [data_width-1:0] dout_1,
    output logic                  valid_1,
    input  logic                  ready_1
`ifdef DEMUX_2_STREAM_CNT_EN
    ,
    output logic [cnt_width-1:0]  cnt_0,
    output logic [cnt_width-1:0]  cnt_1
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t st_0;
    state_t st_1;
    logic   in_xfer;
    logic   wr_0;
    logic   wr_1;
    logic   out_0;
    logic   out_1;

    assign valid_0 = (st_0 == FULL);
    assign valid_1 = (st_1 == FULL);

    // A channel can take a word when it is empty or is being drained in the same cycle.
    assign in_ready = sel ? (~valid_1 | ready_1) : (~valid_0 | ready_0);
    assign in_xfer  = in_valid & in_ready;
    assign wr_0     = in_xfer & ~sel;
    assign wr_1     = in_xfer & sel;
    assign out_0    = valid_0 & ready_0;
    assign out_1    = valid_1 & ready_1;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_0   <= EMPTY;
            st_1   <= EMPTY;
            dout_0 <= '0;
            dout_1 <= '0;
        end else begin
            case (st_0)
                EMPTY: begin
                    if (wr_0) begin
                        st_0   <= FULL;
                        dout_0 <= din;
                    end
                end
                FULL: begin
                    // wr_0 while FULL implies ready_0, so the old word leaves on this edge.
                    if (wr_0) begin
                        dout_0 <= din;
                    end else if (out_0) begin
                        st_0 <= EMPTY;
                    end
                end
                default: st_0 <= EMPTY;
            endcase
            case (st_1)
                EMPTY: begin
                    if (wr_1) begin
                        st_1   <= FULL;
                        dout_1 <= din;
                    end
                end
                FULL: begin
                    if (wr_1) begin
                        dout_1 <= din;
                    end else if (out_1) begin
                        st_1 <= EMPTY;
                    end
                end
                default: st_1 <= EMPTY;
            endcase
        end
    end

`ifdef DEMUX_2_STREAM_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else begin
            if (out_0) cnt_0 <= cnt_0 + 1'b1;
            if (out_1) cnt_1 <= cnt_1 + 1'b1;
        end
    end
`else
    localparam int unused_cnt_width = cnt_width;
`endif

endmodule
